// File: rtl/bram_stream_reader.sv
// Streams length words from a 1-cycle-latency RAM port starting at base_addr; first m_valid 2 cycles after start.
// Reads are throttled so in-flight + buffered words never exceed the 2-entry skid buffer, so m_ready can stall at any time.
module bram_stream_reader #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   length,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   input  logic [DATA_WIDTH-1:0] ram_dout,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last
);
   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

   localparam logic [ADDR_WIDTH:0] REM_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

   state_t                state;
   state_t                state_nxt;
   logic [ADDR_WIDTH:0]   remaining;
   logic                  inflight;
   logic                  inflight_last;
   logic [1:0]            occ;
   logic [DATA_WIDTH-1:0] data0;
   logic [DATA_WIDTH-1:0] data1;
   logic                  last0;
   logic                  last1;
   logic                  pop;
   logic                  issue;
   logic                  accept;
   logic [2:0]            pending;

   assign pop     = m_valid && m_ready;
   assign pending = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
   assign issue   = (state == READ) && (remaining != '0) && (pending <= 3'd1);
   assign accept  = (state == IDLE) && start;

   assign busy    = (state != IDLE);
   assign m_valid = (occ != 2'd0);
   assign m_data  = data0;
   assign m_last  = m_valid && last0;

   always_comb begin
      state_nxt = state;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = (length == '0) ? DRAIN : READ;
         end
         READ: begin
            if (issue && (remaining == REM_ONE)) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (!inflight && (occ == 2'd0)) begin
               done      = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ram_addr always holds the next address to read; a zero-length start leaves it untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         ram_addr      <= '0;
         remaining     <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
      end else begin
         state    <= state_nxt;
         inflight <= issue;
         if (issue) inflight_last <= (remaining == REM_ONE);
         if (accept) begin
            remaining <= length;
            if (length != '0) ram_addr <= base_addr;
         end else if (issue) begin
            remaining <= remaining - REM_ONE;
            ram_addr  <= ram_addr + 1'b1;
         end
      end
   end

   // Entry 0 is the head; a push lands in the first free slot after any same-cycle pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ   <= 2'd0;
         data0 <= '0;
         data1 <= '0;
         last0 <= 1'b0;
         last1 <= 1'b0;
      end else begin
         case ({inflight, pop})
            2'b10: begin
               if (occ == 2'd0) begin
                  data0 <= ram_dout;
                  last0 <= inflight_last;
               end else begin
                  data1 <= ram_dout;
                  last1 <= inflight_last;
               end
               occ <= occ + 2'd1;
            end
            2'b01: begin
               data0 <= data1;
               last0 <= last1;
               occ   <= occ - 2'd1;
            end
            2'b11: begin
               if (occ == 2'd1) begin
                  data0 <= ram_dout;
                  last0 <= inflight_last;
               end else begin
                  data0 <= data1;
                  last0 <= last1;
                  data1 <= ram_dout;
                  last1 <= inflight_last;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader with a 16-word registered-read RAM model.
`timescale 1ns/1ps
module tb_bram_stream_reader;
   localparam int DW = 32;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW:0]   length = '0;
   logic          busy;
   logic          done;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_dout;
   logic          m_valid;
   logic          m_ready = 1'b1;
   logic [DW-1:0] m_data;
   logic          m_last;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] mem [16];

   always #5 clk = ~clk;

   always @(posedge clk) ram_dout <= mem[ram_addr];

   bram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .base_addr (base_addr),
      .length    (length),
      .busy      (busy),
      .done      (done),
      .ram_addr  (ram_addr),
      .ram_dout  (ram_dout),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .m_last    (m_last)
   );

   typedef struct {
      logic [3:0]  base;
      logic [4:0]  len;
      bit          rnd_ready;
      bit          mid_start;
      logic [31:0] exp_first;
      logic [31:0] exp_lastw;
      logic [3:0]  exp_end;
      int          exp_first_k;
      int          exp_done_k;
   } vec_t;

   vec_t vecs [6];
   vec_t post_reset;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // k counts negedges after the start edge E0 (k=0 lies between E0 and E1).
   task automatic run_xfer(input vec_t v, input string tag);
      int          n = 0;
      int          first_k = -1;
      int          last_k = -1;
      int          done_k = -1;
      int          viol = 0;
      logic        hold_ok = 1'b1;
      logic        stalled = 1'b0;
      logic [31:0] held = '0;
      logic [31:0] first_w = '0;
      logic [31:0] last_w = '0;
      logic [3:0]  end_addr = '0;
      @(negedge clk);
      start = 1'b1; base_addr = v.base; length = v.len;
      @(negedge clk);
      start = 1'b0;
      check({tag, " busy after start"}, {31'd0, busy}, 32'd1);
      for (int k = 0; k < 300; k++) begin
         if (v.mid_start && k == 3) begin
            start = 1'b1; base_addr = 4'd9; length = 5'd7;
         end else begin
            start = 1'b0;
         end
         m_ready = v.rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (({1'b0, dut.occ} + {2'b00, dut.inflight}) > 3'd2) viol++;
         if (stalled && !(m_valid && m_data == held)) hold_ok = 1'b0;
         if (m_valid && first_k < 0) first_k = k;
         if (done) begin
            done_k = k;
            end_addr = ram_addr;
            break;
         end
         if (m_valid && m_ready) begin
            check($sformatf("%s beat%0d data", tag, n), m_data, 32'h100 + 32'((int'(v.base) + n) & 15));
            check($sformatf("%s beat%0d last", tag, n), {31'd0, m_last}, {31'd0, (n == int'(v.len) - 1)});
            if (n == 0) first_w = m_data;
            last_w = m_data;
            last_k = k;
            n++;
         end
         stalled = m_valid && !m_ready;
         held = m_data;
         @(negedge clk);
      end
      start = 1'b0;
      check({tag, " done seen within budget"}, {31'd0, (done_k >= 0)}, 32'd1);
      check({tag, " beat count"}, 32'(n), 32'(v.len));
      check({tag, " first valid cycle"}, 32'(first_k), 32'(v.exp_first_k));
      check({tag, " end ram_addr"}, {28'd0, end_addr}, {28'd0, v.exp_end});
      check({tag, " occ+inflight<=2"}, 32'(viol), 32'd0);
      check({tag, " data held while stalled"}, {31'd0, hold_ok}, 32'd1);
      if (v.exp_done_k >= 0) check({tag, " done cycle"}, 32'(done_k), 32'(v.exp_done_k));
      if (v.len != 0) begin
         check({tag, " first word"}, first_w, v.exp_first);
         check({tag, " last word"}, last_w, v.exp_lastw);
         check({tag, " done after last beat"}, 32'(done_k), 32'(last_k + 1));
      end
      @(negedge clk);
      check({tag, " done single pulse"}, {31'd0, done}, 32'd0);
      check({tag, " idle after done"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 32'h100 + 32'(i);

      vecs[0] = '{4'd0,  5'd4,  1'b0, 1'b0, 32'h100, 32'h103, 4'd4,  2, 6};
      vecs[1] = '{4'd7,  5'd0,  1'b0, 1'b0, 32'h000, 32'h000, 4'd4, -1, 0};
      vecs[2] = '{4'd14, 5'd4,  1'b0, 1'b0, 32'h10E, 32'h101, 4'd2,  2, 6};
      vecs[3] = '{4'd3,  5'd16, 1'b1, 1'b0, 32'h103, 32'h102, 4'd3,  2, -1};
      vecs[4] = '{4'd10, 5'd5,  1'b0, 1'b1, 32'h10A, 32'h10E, 4'd15, 2, 7};
      vecs[5] = '{4'd15, 5'd1,  1'b0, 1'b0, 32'h10F, 32'h10F, 4'd0,  2, 3};
      post_reset = '{4'd2, 5'd3, 1'b0, 1'b0, 32'h102, 32'h104, 4'd5, 2, 5};

      repeat (3) @(negedge clk);
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset done", {31'd0, done}, 32'd0);
      check("reset ram_addr", {28'd0, ram_addr}, 32'd0);
      check("reset m_valid", {31'd0, m_valid}, 32'd0);
      check("reset m_data", m_data, 32'd0);
      check("reset m_last", {31'd0, m_last}, 32'd0);
      rst_n = 1'b1;

      for (int t = 0; t < 6; t++) run_xfer(vecs[t], $sformatf("vec%0d", t));

      // Abandon a stalled transfer with an asynchronous reset, then run a fresh one.
      @(negedge clk);
      start = 1'b1; base_addr = 4'd5; length = 5'd8; m_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      check("rst mid valid before", {31'd0, m_valid}, 32'd1);
      check("rst mid busy before", {31'd0, busy}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rst mid m_valid", {31'd0, m_valid}, 32'd0);
      check("rst mid busy", {31'd0, busy}, 32'd0);
      check("rst mid done", {31'd0, done}, 32'd0);
      check("rst mid ram_addr", {28'd0, ram_addr}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1; m_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("after release idle", {31'd0, busy}, 32'd0);
      check("after release no valid", {31'd0, m_valid}, 32'd0);
      run_xfer(post_reset, "post_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end
endmodule
